// File: rtl/game_state_ctrl.sv
// Game sequencer: owns game_state, debounces fire, times phases in frames and
// drives the READY UP blink, lives/level counters and new-game/wave pulses.
module game_state_ctrl #(
    parameter int unsigned BLINK_FRAMES       = 30,
    parameter int unsigned DEBOUNCE_FRAMES    = 3,
    parameter int unsigned LEVEL_CLEAR_FRAMES = 120,
    parameter int unsigned GAME_OVER_FRAMES   = 180,
    parameter int unsigned START_LIVES        = 3,
    parameter int unsigned MAX_LEVEL          = 15
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       fsync,
    input  logic       fire_btn,
    input  logic       player_hit,
    input  logic       wave_cleared,
    output logic [1:0] game_state,
    output logic       show_ready,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       game_reset,
    output logic       wave_start
);

    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          run_q;
    logic          sync1_q, sync2_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_cnt_inc;
    logic          deb_q, deb_d, deb_prev_q;
    logic          fire_press;
    logic [7:0]    timer_q, timer_d, timer_inc;
    logic [8:0]    timer_next;
    logic [BW-1:0] blink_q, blink_d;
    logic          show_q, show_d;
    logic [1:0]    lives_q, lives_d;
    logic [3:0]    level_q, level_d;
    logic          game_reset_q, game_reset_d;
    logic          wave_start_q, wave_start_d;
    logic          fatal_hit;

    // run_q delays the first update to the second edge after reset release
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            deb_q        <= 1'b1;
            deb_prev_q   <= 1'b1;
            state_q      <= ST_START;
            timer_q      <= '0;
            blink_q      <= '0;
            show_q       <= 1'b1;
            lives_q      <= '0;
            level_q      <= '0;
            game_reset_q <= 1'b0;
            wave_start_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                sync1_q      <= fire_btn;
                sync2_q      <= sync1_q;
                deb_cnt_q    <= deb_cnt_d;
                deb_q        <= deb_d;
                deb_prev_q   <= deb_q;
                state_q      <= state_d;
                timer_q      <= timer_d;
                blink_q      <= blink_d;
                show_q       <= show_d;
                lives_q      <= lives_d;
                level_q      <= level_d;
                game_reset_q <= game_reset_d;
                wave_start_q <= wave_start_d;
            end
        end
    end

    always_comb begin
        deb_cnt_inc = deb_cnt_q + 1'b1;
        deb_cnt_d   = deb_cnt_q;
        deb_d       = deb_q;
        if (fsync) begin
            if (sync2_q != deb_q) begin
                if (deb_cnt_inc == DW'(DEBOUNCE_FRAMES)) begin
                    deb_d     = sync2_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_inc;
                end
            end else begin
                deb_cnt_d = '0;
            end
        end
    end

    assign fire_press = deb_q & ~deb_prev_q;
    assign fatal_hit  = player_hit && (lives_q <= 2'd1);
    assign timer_inc  = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    assign timer_next = {1'b0, timer_q} + 9'd1;

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        show_d       = show_q;
        blink_d      = blink_q;
        game_reset_d = 1'b0;
        wave_start_d = 1'b0;
        timer_d      = fsync ? timer_inc : timer_q;

        unique case (state_q)
            ST_START: begin
                if (fsync) begin
                    if (blink_q == BW'(BLINK_FRAMES - 1)) begin
                        show_d  = ~show_q;
                        blink_d = '0;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
                if (fire_press) begin
                    state_d      = ST_PLAY;
                    lives_d      = 2'(START_LIVES);
                    level_d      = 4'd1;
                    game_reset_d = 1'b1;
                    wave_start_d = 1'b1;
                    show_d       = 1'b0;
                    blink_d      = '0;
                end
            end
            ST_PLAY: begin
                show_d = 1'b0;
                // A hit is resolved before a simultaneous clear; a fatal hit drops the clear
                if (fatal_hit) begin
                    lives_d = '0;
                    state_d = ST_OVER;
                end else begin
                    if (player_hit) lives_d = lives_q - 2'd1;
                    if (wave_cleared) state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                show_d = 1'b0;
                if (fsync && timer_next == 9'(LEVEL_CLEAR_FRAMES)) begin
                    state_d      = ST_PLAY;
                    level_d      = (level_q >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_q + 4'd1;
                    wave_start_d = 1'b1;
                end
            end
            ST_OVER: begin
                show_d = 1'b0;
                if (fsync && timer_next == 9'(GAME_OVER_FRAMES)) begin
                    state_d = ST_START;
                    show_d  = 1'b1;
                    blink_d = '0;
                end
            end
            default: state_d = ST_START;
        endcase

        if (state_d != state_q) timer_d = '0;
    end

    assign game_state = state_q;
    assign show_ready = show_q;
    assign lives      = lives_q;
    assign level      = level_q;
    assign game_reset = game_reset_q;
    assign wave_start = wave_start_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: reset, blink, debounce, lives, level
// clear and game-over sequencing with hand-computed expectations.
module tb_game_state_ctrl;

    logic       pixel_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fsync = 1'b0;
    logic       fire_btn = 1'b0;
    logic       player_hit = 1'b0;
    logic       wave_cleared = 1'b0;
    logic [1:0] game_state;
    logic       show_ready;
    logic [1:0] lives;
    logic [3:0] level;
    logic       game_reset;
    logic       wave_start;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_START = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2, S_CLEAR = 2'd3;

    game_state_ctrl #(
        .BLINK_FRAMES(30), .DEBOUNCE_FRAMES(3), .LEVEL_CLEAR_FRAMES(120),
        .GAME_OVER_FRAMES(180), .START_LIVES(3), .MAX_LEVEL(15)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .fire_btn(fire_btn),
        .player_hit(player_hit), .wave_cleared(wave_cleared), .game_state(game_state),
        .show_ready(show_ready), .lives(lives), .level(level),
        .game_reset(game_reset), .wave_start(wave_start)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic tick;
        @(posedge pixel_clk);
        #1;
    endtask

    // Three idle cycles then one fsync cycle; returns just after the fsync edge
    task automatic frame;
        repeat (3) tick();
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
    endtask

    task automatic pulse_hit(input logic also_clear);
        player_hit   = 1'b1;
        wave_cleared = also_clear;
        tick();
        player_hit   = 1'b0;
        wave_cleared = 1'b0;
    endtask

    task automatic start_game;
        fire_btn = 1'b1;
        repeat (3) frame();
        tick();
        fire_btn = 1'b0;
        checks++;
        if (game_state !== S_PLAY || lives !== 2'd3 || level !== 4'd1) begin
            errors++;
            $display("FAIL start_game: state=%0d lives=%0d level=%0d expected 1/3/1", game_state, lives, level);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (game_state !== S_START || show_ready !== 1'b1 || lives !== 2'd0 || level !== 4'd0 ||
            game_reset !== 1'b0 || wave_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d show=%0b lives=%0d level=%0d gr=%0b ws=%0b expected 0/1/0/0/0/0",
                     game_state, show_ready, lives, level, game_reset, wave_start);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_blink;
        logic exp;
        for (int k = 1; k <= 90; k++) begin
            frame();
            exp = ((k / 30) % 2) == 0;
            checks++;
            if (show_ready !== exp || game_state !== S_START) begin
                errors++;
                $display("FAIL blink frame %0d: show=%0b state=%0d expected show=%0b state=0", k, show_ready, game_state, exp);
            end
        end
    endtask

    task automatic test_debounce;
        fire_btn = 1'b1;
        repeat (2) frame();
        fire_btn = 1'b0;
        repeat (3) frame();
        checks++;
        if (game_state !== S_START || game_reset !== 1'b0) begin
            errors++;
            $display("FAIL debounce_short: state=%0d gr=%0b expected 0/0", game_state, game_reset);
        end
        fire_btn = 1'b1;
        repeat (3) frame();
        checks++;
        if (game_state !== S_START) begin
            errors++;
            $display("FAIL debounce_early: state=%0d expected 0", game_state);
        end
        tick();
        checks++;
        if (game_state !== S_PLAY || game_reset !== 1'b1 || wave_start !== 1'b1 ||
            lives !== 2'd3 || level !== 4'd1 || show_ready !== 1'b0) begin
            errors++;
            $display("FAIL game_start: state=%0d gr=%0b ws=%0b lives=%0d level=%0d show=%0b expected 1/1/1/3/1/0",
                     game_state, game_reset, wave_start, lives, level, show_ready);
        end
        tick();
        checks++;
        if (game_reset !== 1'b0 || wave_start !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse_width: gr=%0b ws=%0b expected 0/0", game_reset, wave_start);
        end
        frame();
        fire_btn = 1'b0;
        repeat (4) frame();
        checks++;
        if (game_state !== S_PLAY || lives !== 2'd3 || game_reset !== 1'b0) begin
            errors++;
            $display("FAIL fire_in_play: state=%0d lives=%0d gr=%0b expected 1/3/0", game_state, lives, game_reset);
        end
    endtask

    task automatic test_hits;
        pulse_hit(1'b0);
        checks++;
        if (lives !== 2'd2 || game_state !== S_PLAY) begin
            errors++;
            $display("FAIL hit1: lives=%0d state=%0d expected 2/1", lives, game_state);
        end
        pulse_hit(1'b0);
        checks++;
        if (lives !== 2'd1 || game_state !== S_PLAY) begin
            errors++;
            $display("FAIL hit2: lives=%0d state=%0d expected 1/1", lives, game_state);
        end
        pulse_hit(1'b0);
        checks++;
        if (lives !== 2'd0 || game_state !== S_OVER || level !== 4'd1) begin
            errors++;
            $display("FAIL hit3: lives=%0d state=%0d level=%0d expected 0/2/1", lives, game_state, level);
        end
        fire_btn = 1'b1;
        repeat (5) frame();
        fire_btn = 1'b0;
        repeat (174) frame();
        checks++;
        if (game_state !== S_OVER || show_ready !== 1'b0) begin
            errors++;
            $display("FAIL game_over_hold: state=%0d show=%0b expected 2/0", game_state, show_ready);
        end
        frame();
        checks++;
        if (game_state !== S_START || show_ready !== 1'b1 || lives !== 2'd0 || level !== 4'd1 ||
            game_reset !== 1'b0 || wave_start !== 1'b0) begin
            errors++;
            $display("FAIL game_over_exit: state=%0d show=%0b lives=%0d level=%0d gr=%0b ws=%0b expected 0/1/0/1/0/0",
                     game_state, show_ready, lives, level, game_reset, wave_start);
        end
    endtask

    task automatic test_hit_and_clear;
        start_game();
        pulse_hit(1'b0);
        pulse_hit(1'b1);
        checks++;
        if (lives !== 2'd1 || game_state !== S_CLEAR) begin
            errors++;
            $display("FAIL hit_clear_nonfatal: lives=%0d state=%0d expected 1/3", lives, game_state);
        end
        repeat (60) frame();
        pulse_hit(1'b1);
        repeat (59) frame();
        checks++;
        if (game_state !== S_CLEAR || lives !== 2'd1 || wave_start !== 1'b0) begin
            errors++;
            $display("FAIL clear_hold: state=%0d lives=%0d ws=%0b expected 3/1/0", game_state, lives, wave_start);
        end
        frame();
        checks++;
        if (game_state !== S_PLAY || level !== 4'd2 || wave_start !== 1'b1 || game_reset !== 1'b0) begin
            errors++;
            $display("FAIL clear_exit: state=%0d level=%0d ws=%0b gr=%0b expected 1/2/1/0", game_state, level, wave_start, game_reset);
        end
        tick();
        checks++;
        if (wave_start !== 1'b0) begin
            errors++;
            $display("FAIL wave_pulse_width: ws=%0b expected 0", wave_start);
        end
        pulse_hit(1'b1);
        checks++;
        if (lives !== 2'd0 || game_state !== S_OVER || level !== 4'd2) begin
            errors++;
            $display("FAIL hit_clear_fatal: lives=%0d state=%0d level=%0d expected 0/2/2", lives, game_state, level);
        end
        repeat (180) frame();
        checks++;
        if (game_state !== S_START || show_ready !== 1'b1) begin
            errors++;
            $display("FAIL fatal_return: state=%0d show=%0b expected 0/1", game_state, show_ready);
        end
    endtask

    task automatic test_level_saturate;
        logic [3:0] exp_level;
        start_game();
        for (int i = 0; i < 15; i++) begin
            exp_level = (i < 14) ? 4'(i + 2) : 4'd15;
            if (i == 14) begin
                // clear coincides with fsync: that fsync must not be counted
                wave_cleared = 1'b1;
                fsync        = 1'b1;
                tick();
                wave_cleared = 1'b0;
                fsync        = 1'b0;
                fire_btn     = 1'b1;
                repeat (5) frame();
                fire_btn     = 1'b0;
                repeat (114) frame();
            end else begin
                wave_cleared = 1'b1;
                tick();
                wave_cleared = 1'b0;
                repeat (119) frame();
            end
            checks++;
            if (game_state !== S_CLEAR) begin
                errors++;
                $display("FAIL level_clear_hold %0d: state=%0d expected 3", i, game_state);
            end
            frame();
            checks++;
            if (game_state !== S_PLAY || level !== exp_level || wave_start !== 1'b1) begin
                errors++;
                $display("FAIL level_step %0d: state=%0d level=%0d ws=%0b expected 1/%0d/1", i, game_state, level, wave_start, exp_level);
            end
        end
    endtask

    task automatic test_reset_mid_play;
        repeat (5) frame();
        pulse_hit(1'b0);
        checks++;
        if (lives !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_lives: lives=%0d expected 2", lives);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (game_state !== S_START || show_ready !== 1'b1 || lives !== 2'd0 || level !== 4'd0 ||
            game_reset !== 1'b0 || wave_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d show=%0b lives=%0d level=%0d gr=%0b ws=%0b expected 0/1/0/0/0/0",
                     game_state, show_ready, lives, level, game_reset, wave_start);
        end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_blink();
        test_debounce();
        test_hits();
        test_hit_and_clear();
        test_level_saturate();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game sequencer that owns `game_state` and drives the start/ready-up overlay, play, level-clear and game-over phases.
- Debounces the fire button and times every phase in frames (counts `fsync` pulses).
- Produces the frame-locked READY UP blink (`show_ready`), plus lives/level counters and reset/wave-start pulses for the sprite and enemy blocks.
- Sits between the input pins and the screen renderers, all in the `pixel_clk` domain.

Parameters:
- BLINK_FRAMES, 30, `fsync` pulses per `show_ready` half-period.
- DEBOUNCE_FRAMES, 3, consecutive `fsync` samples of a stable synced button required to change the debounced level.
- LEVEL_CLEAR_FRAMES, 120, duration of the LEVEL_CLEAR phase in frames.
- GAME_OVER_FRAMES, 180, duration of the GAME_OVER phase in frames.
- START_LIVES, 3, lives loaded at game start (1..3).
- MAX_LEVEL, 15, saturation value of `level`.

Ports:
- pixel_clk  input  1  pixel clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fsync  input  1  one-cycle pulse per frame (start of vertical blank).
- fire_btn  input  1  raw asynchronous fire button, active-high.
- player_hit  input  1  one-cycle pulse: the player ship was destroyed.
- wave_cleared  input  1  one-cycle pulse: all enemies in the wave are destroyed.
- game_state  output  2  0=START_SCREEN, 1=PLAYING, 2=GAME_OVER, 3=LEVEL_CLEAR.
- show_ready  output  1  READY UP text visible; meaningful only in START_SCREEN.
- lives  output  2  remaining lives.
- level  output  4  current level, 1..MAX_LEVEL during a game.
- game_reset  output  1  one-cycle pulse: clear score, sprites and enemies for a new game.
- wave_start  output  1  one-cycle pulse: spawn a new enemy wave.

Behaviour:
- Reset (`rst_n`=0, asynchronous) forces:
  - `game_state`=START_SCREEN, `show_ready`=1, `lives`=0, `level`=0;
  - `game_reset`=0, `wave_start`=0;
  - frame timer=0, debounce counter=0, debounced level=1 (so a button held through reset does not start a game).
- Release from reset is synchronised internally: the first state update happens on the second `pixel_clk` edge after `rst_n` rises.
- Button path:
  - `fire_btn` goes through a 2-flop synchronizer.
  - On each `fsync`: if the synced value differs from the debounced level, the debounce counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_FRAMES, the debounced level takes the synced value and the counter clears.
  - `fire_press` is a one-cycle internal pulse on the debounced 0->1 edge.
- Frame timer: 8-bit. Cleared on every state change; otherwise increments on `fsync`, saturating at 255.
- START_SCREEN:
  - `show_ready` toggles when the blink counter reaches BLINK_FRAMES-1 on an `fsync`; the blink counter then wraps to 0.
  - On `fire_press`: go to PLAYING, `lives`<=START_LIVES, `level`<=1, and pulse `game_reset` and `wave_start` in the cycle the state changes.
- PLAYING:
  - `player_hit` with `lives`>1: `lives` decrements.
  - `player_hit` with `lives`==1: `lives`<=0, go to GAME_OVER.
  - `wave_cleared` (no fatal hit in the same cycle): go to LEVEL_CLEAR.
  - `player_hit` and `wave_cleared` in the same cycle: the hit is processed first. If it is fatal, go to GAME_OVER and drop the clear; otherwise `lives` decrements and the state goes to LEVEL_CLEAR.
  - `fire_press` is ignored by this block.
- LEVEL_CLEAR: on the `fsync` on which the frame timer would reach LEVEL_CLEAR_FRAMES, go to PLAYING, `level`<=min(`level`+1, MAX_LEVEL), and pulse `wave_start`. `player_hit` and `wave_cleared` are ignored.
- GAME_OVER: after GAME_OVER_FRAMES `fsync` pulses, go to START_SCREEN. `fire_press`, `player_hit` and `wave_cleared` are ignored. `lives` and `level` hold their values for the score display.
- Entry to START_SCREEN: `show_ready`<=1 and the blink counter clears.
- Outside START_SCREEN, `show_ready`=0.
- Event and `fsync` in the same cycle: both take effect; a state change clears the timer and that `fsync` is not counted.
- `game_reset` and `wave_start` are registered, exactly one cycle wide, and never asserted outside the transitions named above.

Test Plan:
- Reset asserted mid-PLAYING with `lives`=2 -> outputs return immediately to START_SCREEN, `show_ready`=1, `lives`=0, `level`=0, no pulses.
- In START_SCREEN, hold `fire_btn`=1 for 2 frames, then 0 -> no transition. Hold for 4 frames -> PLAYING within one cycle of the 3rd qualifying `fsync`; `game_reset`=`wave_start`=1 for exactly one cycle; `lives`=3, `level`=1.
- Idle START_SCREEN for 90 frames -> `show_ready` sequence 1,0,1,0 with edges exactly at `fsync` 30, 60, 90.
- PLAYING, `lives`=3: three `player_hit` pulses -> `lives` 2, 1, then 0 with GAME_OVER; after 180 `fsync` -> START_SCREEN, `show_ready`=1.
- PLAYING, `lives`=2: `player_hit` and `wave_cleared` in the same cycle -> `lives`=1, LEVEL_CLEAR. After 120 frames -> PLAYING, `level`=2, one-cycle `wave_start`. Same stimulus with `lives`=1 -> GAME_OVER, `level` unchanged.
- From `level`=15, complete a LEVEL_CLEAR -> `level` stays 15; fire presses during GAME_OVER/LEVEL_CLEAR -> no state change.
